// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, fixed-point constant and FSM encoding for the output neuron
package nn_pkg;
  localparam int HW = 10;
  localparam int WW = 8;
  localparam int OW = 12;
  localparam int FRAC = 7;
  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_e;
endpackage

// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit: signed multiply-accumulate of an unsigned hidden value and a signed weight
module neuron_mac_unit #(
  parameter int HW = nn_pkg::HW,
  parameter int WW = nn_pkg::WW,
  parameter int AW = 21
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [HW-1:0]        a_i,
  input  logic signed [WW-1:0] b_i,
  output logic signed [AW-1:0] acc_o
);
  logic signed [HW+WW:0] prod;
  logic signed [AW-1:0] acc_q, acc_d;
  assign prod = $signed({1'b0, a_i}) * b_i;
  always_comb acc_d = clr_i ? '0 : en_i ? acc_q + AW'(prod) : acc_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/output_neuron.sv
// output_neuron: sequential dot product of hidden values and weights, then ReLU and saturation
module output_neuron #(
  parameter int N_IN = 4,
  parameter int HW   = nn_pkg::HW,
  parameter int WW   = nn_pkg::WW,
  parameter int OW   = nn_pkg::OW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [N_IN*HW-1:0] hidden_i,
  input  logic [N_IN*WW-1:0] weights_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OW-1:0]      out_o
);
  import nn_pkg::*;
  localparam int AW = HW + WW + $clog2(N_IN) + 1;
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam logic signed [AW-1:0] OMAX = AW'(2**OW - 1);
  state_e state_q, state_d;
  logic [N_IN*HW-1:0] h_q, h_d;
  logic [N_IN*WW-1:0] w_q, w_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] out_q, out_d;
  logic accept, last;
  logic signed [AW-1:0] acc, shifted;
  assign in_ready_o = en_i && state_q == IDLE;
  assign accept = in_ready_o && in_valid_i;
  assign last = idx_q == IW'(N_IN - 1);
  assign shifted = acc >>> FRAC;
  assign out_valid_o = state_q == DONE;
  assign out_o = out_q;
  neuron_mac_unit #(.HW(HW), .WW(WW), .AW(AW)) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .en_i  (en_i && state_q == MAC),
    .a_i   (h_q[idx_q*HW +: HW]),
    .b_i   ($signed(w_q[idx_q*WW +: WW])),
    .acc_o (acc)
  );
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    w_d = w_q;
    idx_d = idx_q;
    out_d = out_q;
    if (en_i)
      case (state_q)
        IDLE: if (in_valid_i) begin
          h_d = hidden_i;
          w_d = weights_i;
          idx_d = '0;
          state_d = MAC;
        end
        MAC: begin
          idx_d = last ? '0 : idx_q + IW'(1);
          state_d = last ? ACT : MAC;
        end
        ACT: begin
          out_d = shifted < 0 ? '0 : shifted > OMAX ? OW'(OMAX) : shifted[OW-1:0];
          state_d = DONE;
        end
        default: state_d = out_ready_i ? IDLE : DONE;
      endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      h_q <= '0;
      w_q <= '0;
      idx_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      w_q <= w_d;
      idx_q <= idx_d;
      out_q <= out_d;
    end
endmodule

// File: tb/tb_output_neuron.sv
// tb_output_neuron: table vectors, corner sequences and random transactions against an integer model
module tb_output_neuron;
  logic clk_i = 0, rst_i = 0, en_i = 1, in_valid_i = 0, out_ready_i = 0;
  logic [39:0] hidden_i = '0;
  logic [31:0] weights_i = '0;
  logic in_ready_o, out_valid_o;
  logic [11:0] out_o;
  int n_chk = 0, n_pass = 0;

  output_neuron dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .hidden_i(hidden_i), .weights_i(weights_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_o(out_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {logic [39:0] h; logic [31:0] w; logic [11:0] exp;} vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [39:0] pk_h(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [31:0] pk_w(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Real-valued dot product in units of 2^-14, floored to 2^-7 and clamped to the output range
  function automatic longint model(input logic [39:0] h, input logic [31:0] w);
    longint s = 0;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] hv = h[k*10 +: 10];
      logic signed [7:0] wv = w[k*8 +: 8];
      s += longint'(hv) * longint'(wv);
    end
    s = s >>> 7;
    return s < 0 ? 0 : s > 4095 ? 4095 : s;
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge where out_valid_o is first seen high
  task automatic transact(input logic [39:0] h, input logic [31:0] w, input int stall_at,
                          input int stall_len, output logic [11:0] res, output int lat);
    en_i = 1;
    hidden_i = h;
    weights_i = w;
    in_valid_i = 1;
    chk("ready_before_accept", in_ready_o, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 0;
    hidden_i = 40'({$urandom, $urandom});
    weights_i = $urandom;
    chk("ready_low_after_accept", in_ready_o, 0);
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      en_i = !(lat >= stall_at && lat < stall_at + stall_len);
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
    end
    en_i = 1;
    res = out_o;
  endtask

  task automatic handshake();
    out_ready_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 0;
    chk("valid_low_after_handshake", out_valid_o, 0);
    chk("ready_after_handshake", in_ready_o, 1);
  endtask

  initial begin
    vec_t tv[7];
    logic [11:0] res, held;
    logic [39:0] rh;
    logic [31:0] rw;
    int lat, sa, sl;
    tv[0] = '{pk_h(128, 128, 128, 128), pk_w(64, 64, 64, 64), 12'd256};
    tv[1] = '{pk_h(256, 128, 0, 512), pk_w(-128, 64, 100, -32), 12'd0};
    tv[2] = '{pk_h(1023, 1023, 1023, 1023), pk_w(127, 127, 127, 127), 12'd4060};
    tv[3] = '{pk_h(1023, 1023, 1023, 1023), pk_w(-128, -128, -128, -128), 12'd0};
    tv[4] = '{pk_h(128, 0, 0, 0), pk_w(127, 0, 0, 0), 12'd127};
    tv[5] = '{pk_h(1, 0, 0, 0), pk_w(-1, 0, 0, 0), 12'd0};
    tv[6] = '{pk_h(200, 0, 0, 0), pk_w(1, 0, 0, 0), 12'd1};

    @(negedge clk_i);
    chk("reset_out", out_o, 0);
    chk("reset_valid", out_valid_o, 0);
    chk("reset_ready", in_ready_o, 1);
    rst_i = 1;
    @(negedge clk_i);
    en_i = 0;
    #1 chk("ready_follows_en", in_ready_o, 0);
    en_i = 1;
    #1 chk("ready_follows_en_hi", in_ready_o, 1);

    for (int i = 0; i < 7; i++) begin
      transact(tv[i].h, tv[i].w, 99, 0, res, lat);
      chk($sformatf("vec%0d_out", i), res, tv[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, 5);
      handshake();
    end

    // Output held by a stalled consumer
    transact(tv[0].h, tv[0].w, 99, 0, res, lat);
    held = res;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("hold_out", out_o, held);
      chk("hold_valid", out_valid_o, 1);
      chk("hold_ready", in_ready_o, 0);
    end
    handshake();
    chk("idle_keeps_out", out_o, 256);

    // Reset in the middle of accumulation
    hidden_i = tv[2].h;
    weights_i = tv[2].w;
    in_valid_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    #1 chk("rst_out", out_o, 0);
    chk("rst_valid", out_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1;
    #1 chk("rst_ready", in_ready_o, 1);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_discarded", out_valid_o, 0);
    transact(tv[0].h, tv[0].w, 99, 0, res, lat);
    chk("post_rst_out", res, 256);
    chk("post_rst_lat", lat, 5);
    handshake();

    // Enable dropped for two MAC edges
    transact(tv[2].h, tv[2].w, 1, 2, res, lat);
    chk("stall_out", res, 4060);
    chk("stall_lat", lat, 7);
    handshake();

    for (int i = 0; i < 20; i++) begin
      rh = 40'({$urandom, $urandom});
      rw = $urandom;
      sa = $urandom_range(0, 4);
      sl = $urandom_range(0, 3);
      transact(rh, rw, sa, sl, res, lat);
      chk($sformatf("rand%0d_out", i), res, model(rh, rw));
      chk($sformatf("rand%0d_lat", i), lat, 5 + sl);
      handshake();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/output_neuron.md
OUTPUT_NEURON -- requirements
Module: output_neuron

Interface
REQ-001 Parameter: N_IN, default 4, number of hidden-neuron inputs summed.
REQ-002 Parameter: HW, default 10, hidden value width, unsigned 3.7 fixed point.
REQ-003 Parameter: WW, default 8, weight width, signed two's-complement 1.7 fixed point.
REQ-004 Parameter: OW, default 12, output width, unsigned 5.7 fixed point.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rst_i  in  1  asynchronous active-low reset.
REQ-008 en_i  in  1  global enable; low freezes all state.
REQ-009 hidden_i  in  N_IN*HW  packed hidden-layer outputs; element k at bits [k*HW +: HW].
REQ-010 weights_i  in  N_IN*WW  packed signed weights; element k at bits [k*WW +: WW].
REQ-011 in_valid_i  in  1  operands on hidden_i/weights_i are valid.
REQ-012 in_ready_o  out  1  block can accept operands.
REQ-013 out_valid_o  out  1  out_o holds a completed result.
REQ-014 out_ready_i  in  1  consumer accepts out_o.
REQ-015 out_o  out  OW  ReLU-activated, saturated neuron output.

Function
REQ-016 FSM states: IDLE, MAC, ACT, DONE; every transition requires en_i high.
REQ-017 in_ready_o is high exactly when state is IDLE and en_i is high.
REQ-018 Acceptance edge: in_valid_i and in_ready_o high; latch all operands, clear accumulator and index, go to MAC.
REQ-019 MAC: each enabled edge adds hidden[idx]*weight[idx] (signed product, HW+WW bits) to accumulator and increments idx.
REQ-020 MAC -> ACT on the edge that processes idx = N_IN-1.
REQ-021 Accumulator: signed, HW+WW+clog2(N_IN)+1 bits (21 at defaults); it never overflows.
REQ-022 ACT: arithmetic right shift of the accumulator by 7 (floor); result < 0 gives 0 (ReLU); result > 2^OW-1 gives 2^OW-1; register into out_o; go to DONE.
REQ-023 DONE: out_valid_o high; out_o and out_valid_o stable until out_ready_i is high on an enabled edge, then return to IDLE.
REQ-024 Latency: out_valid_o rises after the (N_IN+1)th enabled edge following the acceptance edge (5 at defaults); each en_i-low cycle adds one.
REQ-025 No back-to-back accept: in_ready_o is low from acceptance until the edge after the output handshake.
REQ-026 Operand changes on hidden_i/weights_i after acceptance have no effect on the result in progress.
REQ-027 out_o keeps its last value in IDLE; the value is meaningful only while out_valid_o is high.

Reset
REQ-028 rst_i low at any time, including mid-MAC or in DONE, forces state IDLE, accumulator 0, idx 0, latched operands 0, out_o 0, out_valid_o 0, and discards the operation in progress.
REQ-029 After rst_i deasserts, in_ready_o equals en_i.

Structure
REQ-030 Shared package nn_pkg holds HW, WW, OW, the fractional-bit constant (7), and the FSM state encoding.
REQ-031 One sub-module, neuron_mac_unit, performs the signed multiply-accumulate, with clear and enable inputs.

Verification
REQ-032 hidden all 128 (1.0), weights all 64 (0.5) -> out_o = 256 (2.0); out_valid_o rises 5 edges after acceptance.
REQ-033 hidden {256,128,0,512}, weights {-128,64,100,-32} -> sum -40960 -> out_o = 0 (ReLU).
REQ-034 hidden all 1023, weights all 127 -> out_o = 4060; weights all -128 -> out_o = 0.
REQ-035 out_ready_i held low 3 cycles in DONE -> out_o and out_valid_o stable, in_ready_o low; release -> IDLE next edge.
REQ-036 rst_i pulsed low after 2 MAC edges -> all outputs 0, state IDLE immediately; next transaction computes correctly.
REQ-037 en_i low for 2 cycles during MAC -> accumulator frozen, result unchanged, latency 7 edges.
